seg_p2s_tx: RTL and testbench
=============================

Name: seg_p2s_tx

Overview:
- Parallel-to-serial transmitter for the 64-bit eight-digit segment frame produced by the hex-to-segment encoder.
- Latches one frame and shifts it out bit-serially to the board's cascaded 74HC164 segment shift-register chain.
- Drives the chain clock, data, clear and output-enable lines.
- Sits between the segment encoder and the board pins, one instance per display.

Parameters:
FRAME_BITS, 64, number of bits per frame (8 digits x 8 segments)
CLK_DIV, 2, clk cycles per seg_clk half-period (legal range 1..255)

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request transmission of seg_txt; sampled only in IDLE
seg_txt  input  FRAME_BITS  segment frame; bit 0 = digit 0 segment a, active-low segments
busy  output  1  high from the start-accept edge until the LATCH cycle completes
done  output  1  one-cycle pulse in the LATCH cycle
seg_clk  output  1  shift clock to 74HC164 chain; data is taken on its rising edge
seg_dout  output  1  serial data to chain
seg_clrn  output  1  active-low chain clear
seg_pen  output  1  display output enable, high = shown

Behaviour:
- Async reset, rst_n=0: state=IDLE, busy=0, done=0, seg_clk=0, seg_dout=0, seg_clrn=0, seg_pen=0, bit_cnt=0, div_cnt=0, shift_reg=0.
- seg_clrn goes 1 on the first clk edge after rst_n deasserts, then stays 1.
- All outputs are registered; no combinational path from inputs to outputs.
- State IDLE:
  - seg_clk=0.
  - When start=1 at an edge: shift_reg<=seg_txt, seg_dout<=seg_txt[0], bit_cnt<=0, div_cnt<=0, busy<=1, seg_pen<=0, then go to SHIFT_LO.
- State SHIFT_LO:
  - seg_clk=0 for CLK_DIV cycles (div_cnt counts 0..CLK_DIV-1), then go to SHIFT_HI with div_cnt<=0.
- State SHIFT_HI:
  - seg_clk=1 for CLK_DIV cycles.
  - At its final cycle, if bit_cnt==FRAME_BITS-1, go to LATCH.
  - Otherwise: bit_cnt<=bit_cnt+1, shift_reg<=shift_reg>>1, seg_dout<=shift_reg[1], go to SHIFT_LO.
- Bit order and timing:
  - Frame is sent LSB first.
  - seg_dout changes only while seg_clk=0, and is stable CLK_DIV cycles before and through each rising seg_clk.
- State LATCH (one cycle): seg_clk=0, seg_pen<=1, done=1, busy<=0, then IDLE.
- Latency: done is high exactly 2*CLK_DIV*FRAME_BITS+1 cycles after the start-accept edge (257 for the defaults).
- start while busy is ignored; no queueing.
- start held high re-triggers on the first IDLE cycle after LATCH, giving continuous refresh.
- seg_txt changes during a transfer have no effect, since the frame is latched at accept.
- seg_pen stays 0 from reset until the first LATCH.
- Between frames seg_pen falls to 0 at the next accept and returns to 1 at LATCH.
- Reset mid-transfer: immediate return to reset values and the frame is discarded. A new start is needed afterwards.
- bit_cnt width is clog2(FRAME_BITS); div_cnt width is clog2(CLK_DIV)+1. Neither counter wraps past its terminal value.

Decomposition:
- Shared package seg_pkg holds:
  - state enum {IDLE, SHIFT_LO, SHIFT_HI, LATCH}
  - constant SEG_FRAME_BITS=64
  - constant SEG_DIGITS=8
- One natural sub-module: seg_clk_div. It is the div_cnt counter producing a one-cycle half-period tick, with inputs clear and enable.

Test Plan:
- Reset: rst_n low mid-simulation -> all outputs 0 immediately; seg_clrn=1 one edge after release.
- Defaults, seg_txt=64'h0123456789ABCDEF, start pulse -> 64 seg_clk rising edges; data sampled at those edges equals seg_txt[0..63]; done at cycle 257 for 1 cycle; seg_pen=1 after.
- Frames 64'h0 then 64'hFFFF_FFFF_FFFF_FFFF back-to-back with start held high -> busy low for exactly 1 cycle between frames; each frame is bit-exact.
- start pulse plus seg_txt change while busy -> ignored, with no restart; the transmitted frame equals the originally latched value.
- rst_n asserted at bit 30 -> outputs reset; the next start sends a full 64-bit frame from bit 0.
- CLK_DIV=1 instance -> seg_clk period 2 cycles; done at cycle 129; seg_dout stable at every rising seg_clk.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared definitions for the segment display serial transmitter slice.
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } seg_state_t;

    localparam int unsigned SEG_FRAME_BITS = 64;
    localparam int unsigned SEG_DIGITS     = 8;

endpackage

// File: rtl/seg_clk_div.sv
// Half-period counter for the segment shift clock; tick marks the last cycle of a half-period.
module seg_clk_div #(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV) + 1;

    logic [CNT_W-1:0] div_cnt;

    assign tick = enable && (div_cnt == CNT_W'(CLK_DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (clear) begin
            div_cnt <= '0;
        end else if (enable) begin
            if (tick) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg_p2s_tx.sv
// Latches one segment frame and shifts it LSB first into a 74HC164 chain.
module seg_p2s_tx
    import seg_pkg::*;
#(
    parameter int unsigned FRAME_BITS = SEG_FRAME_BITS,
    parameter int unsigned CLK_DIV    = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [FRAME_BITS-1:0] seg_txt,
    output logic                  busy,
    output logic                  done,
    output logic                  seg_clk,
    output logic                  seg_dout,
    output logic                  seg_clrn,
    output logic                  seg_pen
);

    localparam int unsigned BIT_W = $clog2(FRAME_BITS);

    seg_state_t            state;
    logic [BIT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  div_en;
    logic                  div_tick;

    assign div_en = (state == SHIFT_LO) || (state == SHIFT_HI);

    seg_clk_div #(
        .CLK_DIV(CLK_DIV)
    ) u_clk_div (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (!div_en),
        .enable(div_en),
        .tick  (div_tick)
    );

    // seg_clk is registered alongside the state so it tracks SHIFT_HI exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            seg_clk   <= 1'b0;
            seg_dout  <= 1'b0;
            seg_clrn  <= 1'b0;
            seg_pen   <= 1'b0;
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else begin
            seg_clrn <= 1'b1;
            done     <= 1'b0;
            case (state)
                IDLE: begin
                    seg_clk <= 1'b0;
                    if (start) begin
                        shift_reg <= seg_txt;
                        seg_dout  <= seg_txt[0];
                        bit_cnt   <= '0;
                        busy      <= 1'b1;
                        seg_pen   <= 1'b0;
                        state     <= SHIFT_LO;
                    end
                end
                SHIFT_LO: begin
                    if (div_tick) begin
                        seg_clk <= 1'b1;
                        state   <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (div_tick) begin
                        seg_clk <= 1'b0;
                        if (bit_cnt == BIT_W'(FRAME_BITS - 1)) begin
                            done  <= 1'b1;
                            state <= LATCH;
                        end else begin
                            bit_cnt   <= bit_cnt + 1'b1;
                            shift_reg <= shift_reg >> 1;
                            seg_dout  <= shift_reg[1];
                            state     <= SHIFT_LO;
                        end
                    end
                end
                LATCH: begin
                    seg_clk <= 1'b0;
                    seg_pen <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seg_p2s_tx.sv
// Directed bench for seg_p2s_tx: bit order, timing, refresh, ignore-while-busy, reset.
module tb_seg_p2s_tx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start0 = 1'b0;
    logic        start1 = 1'b0;
    logic [63:0] txt0 = '0;
    logic [63:0] txt1 = '0;
    logic        busy0, done0, sclk0, sdout0, clrn0, pen0;
    logic        busy1, done1, sclk1, sdout1, clrn1, pen1;
    logic        sel = 1'b0;
    logic        m_busy, m_done, m_clk, m_dout, m_clrn, m_pen;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_p2s_tx #(.CLK_DIV(2)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .seg_txt(txt0),
        .busy(busy0), .done(done0), .seg_clk(sclk0), .seg_dout(sdout0),
        .seg_clrn(clrn0), .seg_pen(pen0)
    );

    seg_p2s_tx #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .seg_txt(txt1),
        .busy(busy1), .done(done1), .seg_clk(sclk1), .seg_dout(sdout1),
        .seg_clrn(clrn1), .seg_pen(pen1)
    );

    assign m_busy = sel ? busy1  : busy0;
    assign m_done = sel ? done1  : done0;
    assign m_clk  = sel ? sclk1  : sclk0;
    assign m_dout = sel ? sdout1 : sdout0;
    assign m_clrn = sel ? clrn1  : clrn0;
    assign m_pen  = sel ? pen1   : pen0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Caller drives start before the next posedge, which is the accept edge.
    // Negedge k lies between edges E(k-1) and E(k); done first seen at k = latency.
    task automatic xfer(input int div, input bit drop, input bit poke,
                        output logic [63:0] frame, output int nbits, output int lat,
                        output logic busy_k1, output logic pen_k1,
                        output logic done_after, output logic busy_after,
                        output logic pen_after, output int viol);
        logic prev_clk, prev_dout;
        int   last_rise, last_chg;
        frame = '0; nbits = 0; lat = -1; viol = 0; last_rise = -1; last_chg = 0;
        busy_k1 = 1'b0; pen_k1 = 1'b1;
        prev_clk = m_clk; prev_dout = m_dout;
        @(posedge clk);
        if (drop) begin
            #1;
            start0 = 1'b0;
            start1 = 1'b0;
        end
        for (int k = 1; k <= 1000 && lat < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                busy_k1 = m_busy;
                pen_k1  = m_pen;
            end
            if (poke && k == 100) begin
                start0 = 1'b1;
                txt0   = ~txt0;
            end
            if (poke && k == 102) start0 = 1'b0;
            if (m_dout !== prev_dout) begin
                if (m_clk) viol++;
                last_chg = k;
            end
            if (m_clk && !prev_clk) begin
                if (nbits < 64) frame[nbits] = prev_dout;
                nbits++;
                if (last_rise >= 0 && (k - last_rise) != 2 * div) viol++;
                if ((k - last_chg) < div) viol++;
                last_rise = k;
            end
            if (m_done) lat = k;
            prev_clk = m_clk;
            prev_dout = m_dout;
        end
        @(negedge clk);
        done_after = m_done;
        busy_after = m_busy;
        pen_after  = m_pen;
    endtask

    logic [63:0] fr;
    int          nb, lat, viol, rises;
    logic        bk1, pk1, dn_a, bs_a, pn_a, prev_c;

    initial begin
        #3 rst_n = 1'b0;
        #1;
        check_eq("reset_outputs_dut0", 64'({busy0, done0, sclk0, sdout0, clrn0, pen0}), 64'd0);
        check_eq("reset_outputs_dut1", 64'({busy1, done1, sclk1, sdout1, clrn1, pen1}), 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1 check_eq("clrn_before_edge", 64'(clrn0), 64'd0);
        @(posedge clk);
        #1;
        check_eq("clrn_after_release", 64'(clrn0), 64'd1);
        check_eq("pen_idle_after_reset", 64'(pen0), 64'd0);

        // Basic frame, default divider
        @(negedge clk);
        txt0 = 64'h0123_4567_89AB_CDEF;
        start0 = 1'b1;
        xfer(2, 1'b1, 1'b0, fr, nb, lat, bk1, pk1, dn_a, bs_a, pn_a, viol);
        check_eq("basic_frame", fr, 64'h0123_4567_89AB_CDEF);
        check_eq("basic_rises", 64'(nb), 64'd64);
        check_eq("basic_latency", 64'(lat), 64'd257);
        check_eq("basic_busy_at_accept", 64'(bk1), 64'd1);
        check_eq("basic_done_one_cycle", 64'(dn_a), 64'd0);
        check_eq("basic_pen_after", 64'(pn_a), 64'd1);
        check_eq("basic_busy_after", 64'(bs_a), 64'd0);
        check_eq("basic_timing_viol", 64'(viol), 64'd0);

        // Back-to-back refresh with start held high
        @(negedge clk);
        txt0 = 64'h0;
        start0 = 1'b1;
        xfer(2, 1'b0, 1'b0, fr, nb, lat, bk1, pk1, dn_a, bs_a, pn_a, viol);
        check_eq("b2b_frame0", fr, 64'h0);
        check_eq("b2b_pen_falls_at_accept", 64'(pk1), 64'd0);
        check_eq("b2b_busy_gap", 64'(bs_a), 64'd0);
        txt0 = 64'hFFFF_FFFF_FFFF_FFFF;
        xfer(2, 1'b1, 1'b0, fr, nb, lat, bk1, pk1, dn_a, bs_a, pn_a, viol);
        check_eq("b2b_frame1", fr, 64'hFFFF_FFFF_FFFF_FFFF);
        check_eq("b2b_busy_back_high", 64'(bk1), 64'd1);
        check_eq("b2b_latency1", 64'(lat), 64'd257);
        check_eq("b2b_timing_viol", 64'(viol), 64'd0);

        // Start and seg_txt change while busy are ignored
        @(negedge clk);
        txt0 = 64'hA5A5_5A5A_C3C3_3C3C;
        start0 = 1'b1;
        xfer(2, 1'b1, 1'b1, fr, nb, lat, bk1, pk1, dn_a, bs_a, pn_a, viol);
        check_eq("ignore_frame", fr, 64'hA5A5_5A5A_C3C3_3C3C);
        check_eq("ignore_latency", 64'(lat), 64'd257);
        repeat (4) @(negedge clk);
        check_eq("ignore_no_restart", 64'(busy0), 64'd0);

        // Reset in the middle of the frame
        @(negedge clk);
        txt0 = 64'hDEAD_BEEF_CAFE_F00D;
        start0 = 1'b1;
        @(posedge clk);
        #1 start0 = 1'b0;
        rises = 0;
        prev_c = sclk0;
        for (int k = 0; k < 1000 && rises < 30; k++) begin
            @(negedge clk);
            if (sclk0 && !prev_c) rises++;
            prev_c = sclk0;
        end
        check_eq("midreset_reached_bit30", 64'(rises), 64'd30);
        #2 rst_n = 1'b0;
        #1;
        check_eq("midreset_outputs", 64'({busy0, done0, sclk0, sdout0, clrn0, pen0}), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 check_eq("midreset_clrn", 64'(clrn0), 64'd1);
        repeat (3) @(negedge clk);
        check_eq("midreset_stays_idle", 64'(busy0), 64'd0);
        txt0 = 64'h1122_3344_5566_7788;
        start0 = 1'b1;
        xfer(2, 1'b1, 1'b0, fr, nb, lat, bk1, pk1, dn_a, bs_a, pn_a, viol);
        check_eq("after_reset_frame", fr, 64'h1122_3344_5566_7788);
        check_eq("after_reset_rises", 64'(nb), 64'd64);
        check_eq("after_reset_latency", 64'(lat), 64'd257);

        // CLK_DIV=1 instance
        @(negedge clk);
        sel = 1'b1;
        txt1 = 64'h8000_0000_0000_0001;
        start1 = 1'b1;
        #1;
        xfer(1, 1'b1, 1'b0, fr, nb, lat, bk1, pk1, dn_a, bs_a, pn_a, viol);
        check_eq("div1_frame", fr, 64'h8000_0000_0000_0001);
        check_eq("div1_rises", 64'(nb), 64'd64);
        check_eq("div1_latency", 64'(lat), 64'd129);
        check_eq("div1_timing_viol", 64'(viol), 64'd0);
        check_eq("div1_pen_after", 64'(pn_a), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
